// File: rtl/booth_multiplier_pipelined_if.sv
// Operand/result bus of the pipelined Booth multiplier.
//
// Handshake: both sides use strict valid/ready. A beat moves on a rising
// edge only when valid and ready are both 1 in the cycle before it. A
// producer holds its payload stable while valid=1 and ready=0. ready_o
// never depends on valid_i.
interface booth_multiplier_pipelined_if #(
  parameter int WIDTH = 64
) ();
  logic               valid_i;
  logic               ready_o;
  logic [WIDTH-1:0]   a_i;
  logic [WIDTH-1:0]   b_i;
  logic               signed_a_i;
  logic               signed_b_i;
  logic               valid_o;
  logic               ready_i;
  logic [2*WIDTH-1:0] result_o;

  // The producer of operands and the consumer of results.
  modport master (
    output valid_i, a_i, b_i, signed_a_i, signed_b_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  // The multiplier itself.
  modport slave (
    input  valid_i, a_i, b_i, signed_a_i, signed_b_i, ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/booth_multiplier_pipelined.sv
// Pipelined radix-4 Booth multiplier with a 4:2 compressor reduction tree.
// Three register stages: extended operands, tree sum/carry, final product.
// A single global stall freezes every stage while the output is blocked.
module booth_multiplier_pipelined #(
  parameter int WIDTH = 64
) (
  input  logic clk,
  input  logic rst,
  booth_multiplier_pipelined_if.slave bus
);
  localparam int EW   = WIDTH + 2;      // extended operand width
  localparam int NPP  = WIDTH / 2 + 1;  // Booth partial products
  localparam int PW   = 2 * WIDTH + 4;  // partial-product row width
  localparam int NROW = NPP + 1;        // partial products plus correction row
  localparam int NLVL = 8;              // enough levels for NROW <= 66
  localparam int RW   = 2 * WIDTH;      // result width

  logic          stall;
  logic          v1, v2, v3;
  logic [EW-1:0] a_s1, b_s1;
  logic [RW-1:0] sum_s2, carry_s2;
  logic [RW-1:0] res_s3;
  logic [PW-1:0] pp_rows [NROW];
  logic [PW-1:0] tree_sum, tree_carry;

  // Global stall: only a held, valid output can block the pipe.
  assign stall        = v3 & ~bus.ready_i;
  assign bus.ready_o  = ~stall;
  assign bus.valid_o  = v3;
  assign bus.result_o = res_s3;

  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, y, z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, y, z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  // Stage 1: capture operands, sign- or zero-extended to WIDTH+2 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (!stall) begin
      v1   <= bus.valid_i;
      a_s1 <= {{2{bus.signed_a_i & bus.a_i[WIDTH-1]}}, bus.a_i};
      b_s1 <= {{2{bus.signed_b_i & bus.b_i[WIDTH-1]}}, bus.b_i};
    end
  end

  // Booth recoding of a; each group picks 0, +-b or +-2b. Negative rows are
  // inverted here and their +1 lands in the shared correction row.
  always_comb begin : booth_rows
    logic [EW:0]   a_pad;
    logic [PW-1:0] b_ext;
    logic [PW-1:0] corr;
    logic [PW-1:0] pp;
    logic [2:0]    trip;
    logic          zero, neg, dbl;
    a_pad = {a_s1, 1'b0};
    b_ext = {{(PW-EW){b_s1[EW-1]}}, b_s1};
    corr  = '0;
    pp    = '0;
    trip  = '0;
    zero  = 1'b0;
    neg   = 1'b0;
    dbl   = 1'b0;
    for (int r = 0; r < NROW; r++) pp_rows[r] = '0;
    for (int i = 0; i < NPP; i++) begin
      trip = a_pad[2*i +: 3];
      zero = (trip == 3'b000) || (trip == 3'b111);
      dbl  = (trip == 3'b011) || (trip == 3'b100);
      neg  = trip[2] & ~zero;
      pp   = zero ? '0 : (dbl ? (b_ext << 1) : b_ext);
      if (neg) pp = ~pp;
      pp_rows[i] = pp << (2 * i);
      corr[2*i]  = neg;
    end
    pp_rows[NPP] = corr;
  end

  // Reduction: groups of four rows go through a 4:2 compressor, a left-over
  // group of three through a 3:2 counter, one or two left-over rows pass.
  always_comb begin : reduce_tree
    logic [PW-1:0] cur [NROW];
    logic [PW-1:0] nxt [NROW];
    logic [PW-1:0] s1, c1;
    int n, m, base;
    s1 = '0;
    c1 = '0;
    for (int r = 0; r < NROW; r++) begin
      cur[r] = pp_rows[r];
      nxt[r] = '0;
    end
    n = NROW;
    for (int lvl = 0; lvl < NLVL; lvl++) begin
      if (n > 2) begin
        m = 0;
        for (int r = 0; r < NROW; r++) nxt[r] = '0;
        for (int g = 0; g < NROW / 4; g++) begin
          if (4 * g + 3 < n) begin
            s1       = csa_sum  (cur[4*g], cur[4*g+1], cur[4*g+2]);
            c1       = csa_carry(cur[4*g], cur[4*g+1], cur[4*g+2]);
            nxt[m]   = csa_sum  (s1, c1, cur[4*g+3]);
            nxt[m+1] = csa_carry(s1, c1, cur[4*g+3]);
            m        = m + 2;
          end
        end
        base = (n / 4) * 4;
        if (n - base == 3) begin
          nxt[m]   = csa_sum  (cur[base], cur[base+1], cur[base+2]);
          nxt[m+1] = csa_carry(cur[base], cur[base+1], cur[base+2]);
          m        = m + 2;
        end else if (n - base == 2) begin
          nxt[m]   = cur[base];
          nxt[m+1] = cur[base+1];
          m        = m + 2;
        end else if (n - base == 1) begin
          nxt[m] = cur[base];
          m      = m + 1;
        end
        for (int r = 0; r < NROW; r++) cur[r] = nxt[r];
        n = m;
      end
    end
    tree_sum   = cur[0];
    tree_carry = cur[1];
  end

  // Stage 2: capture the two surviving tree rows (low 2*WIDTH bits suffice).
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
    end else if (!stall) begin
      v2       <= v1;
      sum_s2   <= tree_sum[RW-1:0];
      carry_s2 <= tree_carry[RW-1:0];
    end
  end

  // Stage 3: final carry-propagate add into the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3     <= 1'b0;
      res_s3 <= '0;
    end else if (!stall) begin
      v3 <= v2;
      if (v2) res_s3 <= sum_s2 + carry_s2;
    end
  end
endmodule

// File: tb/tb_booth_multiplier_pipelined.sv
// Bench for booth_multiplier_pipelined at WIDTH 8, 16 and 64.
module tb_booth_multiplier_pipelined;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [127:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  booth_multiplier_pipelined_if #(.WIDTH(8))  if8  ();
  booth_multiplier_pipelined_if #(.WIDTH(16)) if16 ();
  booth_multiplier_pipelined_if #(.WIDTH(64)) if64 ();

  booth_multiplier_pipelined #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8));
  booth_multiplier_pipelined #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(if16));
  booth_multiplier_pipelined #(.WIDTH(64)) u64 (.clk(clk), .rst(rst), .bus(if64));

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference product: extend each operand by its flag, multiply wide.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, b, input logic sa, sb);
    logic signed [129:0] ea, eb, p;
    ea = {{66{sa & a[63]}}, a};
    eb = {{66{sb & b[63]}}, b};
    p  = ea * eb;
    return p[127:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic [63:0] a, b, input logic sa, sb, v);
    case (w)
      8: begin
        if8.a_i = a[7:0]; if8.b_i = b[7:0];
        if8.signed_a_i = sa; if8.signed_b_i = sb; if8.valid_i = v;
      end
      16: begin
        if16.a_i = a[15:0]; if16.b_i = b[15:0];
        if16.signed_a_i = sa; if16.signed_b_i = sb; if16.valid_i = v;
      end
      default: begin
        if64.a_i = a; if64.b_i = b;
        if64.signed_a_i = sa; if64.signed_b_i = sb; if64.valid_i = v;
      end
    endcase
  endtask

  function automatic logic vld_of(input int w);
    case (w)
      8:       return if8.valid_o;
      16:      return if16.valid_o;
      default: return if64.valid_o;
    endcase
  endfunction

  function automatic logic [127:0] res_of(input int w);
    case (w)
      8:       return {112'd0, if8.result_o};
      16:      return {96'd0, if16.result_o};
      default: return if64.result_o;
    endcase
  endfunction

  // One isolated beat: checks the output is absent for two edges, then
  // present with the expected product on the third.
  task automatic one_beat(input string tag, input int w, input logic [63:0] a, b,
                          input logic sa, sb, input logic [127:0] exp);
    drive(w, a, b, sa, sb, 1'b1);
    tick();
    drive(w, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    check({tag, "_lat1"}, {127'd0, vld_of(w)}, 128'd0);
    tick();
    check({tag, "_lat2"}, {127'd0, vld_of(w)}, 128'd0);
    tick();
    check({tag, "_vld"}, {127'd0, vld_of(w)}, 128'd1);
    check({tag, "_prod"}, res_of(w), exp);
    tick();
  endtask

  // Stream n beats into the 64-bit unit with ready_i low for stlen cycles
  // starting at cycle st0. rnd=0 uses a=k+1, b=3 unsigned.
  task automatic stream(input string tag, input int n, input int st0, input int stlen, input bit rnd);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic [63:0] a, b;
    logic sa, sb, was_stall, hold_v;
    logic [127:0] hold_r;
    exp_q.delete();
    while (got < n && cyc < n + stlen + 60) begin
      if64.ready_i = !(cyc >= st0 && cyc < st0 + stlen);
      if (sent < n) begin
        if (rnd) begin
          a = {$urandom, $urandom}; b = {$urandom, $urandom};
          sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
        end else begin
          a = 64'(sent + 1); b = 64'd3; sa = 1'b0; sb = 1'b0;
        end
        drive(64, a, b, sa, sb, 1'b1);
      end else begin
        drive(64, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      end
      #1;
      if (!if64.ready_i && if64.valid_o)
        check({tag, "_ready_lo"}, {127'd0, if64.ready_o}, 128'd0);
      was_stall = !if64.ready_o;
      hold_v    = if64.valid_o;
      hold_r    = if64.result_o;
      if (if64.valid_o && if64.ready_i) begin
        if (exp_q.size() == 0) check({tag, "_extra"}, if64.result_o, 128'd0 - 1);
        else check({tag, "_prod"}, if64.result_o, exp_q.pop_front());
        got++;
      end
      if (if64.valid_i && if64.ready_o) begin
        exp_q.push_back(ref_mul(a, b, sa, sb));
        sent++;
      end
      tick();
      cyc++;
      if (was_stall) begin
        check({tag, "_hold_v"}, {127'd0, if64.valid_o}, {127'd0, hold_v});
        check({tag, "_hold_r"}, if64.result_o, hold_r);
      end
    end
    drive(64, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    if64.ready_i = 1'b1;
    check({tag, "_count"}, 128'(got), 128'(n));
    check({tag, "_cycles"}, 128'(cyc), 128'(n + 3 + stlen));
    check({tag, "_q_empty"}, 128'(exp_q.size()), 128'd0);
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    drive(8, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    drive(16, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    drive(64, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    if8.ready_i = 1'b1; if16.ready_i = 1'b1; if64.ready_i = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check("rst_v8",   {127'd0, if8.valid_o},  128'd0);
    check("rst_r8",   res_of(8),              128'd0);
    check("rst_rdy8", {127'd0, if8.ready_o},  128'd1);
    check("rst_v64",  {127'd0, if64.valid_o}, 128'd0);
    check("rst_r64",  res_of(64),             128'd0);
    check("rst_rdy64",{127'd0, if64.ready_o}, 128'd1);

    // WIDTH=8
    one_beat("w8_ss_min_min", 8, 64'h80, 64'h80, 1'b1, 1'b1, 128'h4000);
    one_beat("w8_ss_min_max", 8, 64'h80, 64'h7F, 1'b1, 1'b1, 128'hC080);
    one_beat("w8_uu_ff_ff",   8, 64'hFF, 64'hFF, 1'b0, 1'b0, 128'hFE01);
    one_beat("w8_su_m1_255",  8, 64'hFF, 64'hFF, 1'b1, 1'b0, 128'hFF01);
    one_beat("w8_us_255_m1",  8, 64'hFF, 64'hFF, 1'b0, 1'b1, 128'hFF01);
    one_beat("w8_ss_7_m3",    8, 64'h07, 64'hFD, 1'b1, 1'b1, 128'hFFEB);

    // WIDTH=16 edge operands
    one_beat("w16_zero",      16, 64'h0000, 64'h1234, 1'b1, 1'b1, 128'h0);
    one_beat("w16_one_u",     16, 64'h0001, 64'hBEEF, 1'b0, 1'b0, 128'h0000BEEF);
    one_beat("w16_one_s",     16, 64'h0001, 64'hBEEF, 1'b1, 1'b1, 128'hFFFFBEEF);
    one_beat("w16_min_min",   16, 64'h8000, 64'h8000, 1'b1, 1'b1, 128'h40000000);
    one_beat("w16_max_max_u", 16, 64'hFFFF, 64'hFFFF, 1'b0, 1'b0, 128'hFFFE0001);

    // WIDTH=64 edge operands
    one_beat("w64_m1_m1_s", 64, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             1'b1, 1'b1, 128'h1);
    one_beat("w64_max_max_u", 64, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             1'b0, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    one_beat("w64_min_min_s", 64, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             1'b1, 1'b1, 128'h4000_0000_0000_0000_0000_0000_0000_0000);

    // Backpressure mid-stream, then a full-rate random stream.
    stream("bp", 6, 5, 4, 1'b0);
    stream("rnd", 300, 0, 0, 1'b1);

    // Reset with three beats in flight plus one offered alongside rst.
    for (int k = 0; k < 3; k++) begin
      drive(64, 64'(k + 10), 64'd9, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(64, 64'd99, 64'd99, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(64, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    check("mrst_v", {127'd0, if64.valid_o}, 128'd0);
    check("mrst_r", res_of(64), 128'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("mrst_stale%0d", k), {127'd0, if64.valid_o}, 128'd0);
    end
    one_beat("mrst_next", 64, 64'd5, 64'd7, 1'b0, 1'b0, 128'd35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
